ssd_reader: RTL and testbench

SSD_READER -- requirements
Module: ssd_reader

---
 rtl/ssd_reader.sv | 163 ++++++++++++++++
 tb/tb_ssd_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_reader.sv
// Recovers the digit codes shown on a multiplexed 7-segment display by sampling its anode/segment pins.
// Optional SSD_READER_ERRCNT_EN adds err_cnt, a saturating count of commits of the invalid code.
module ssd_reader #(
    parameter int NUM_DIGITS = 4,
    parameter int SETTLE_CYC = 8,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [5*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic [2:0]              upd_idx
`ifdef SSD_READER_ERRCNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;
    logic [7:0]            settle;
    logic [3:0]            zeros;
    logic                  one_hot;
    logic                  sample;
    logic [2:0]            sel;
    logic [4:0]            code;
    logic [4:0]            cand [NUM_DIGITS];
    logic [3:0]            match_cnt [NUM_DIGITS];
    logic                  pend;
    logic [2:0]            pend_idx;
    logic [4:0]            pend_code;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0011000: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b0000011: decode = 5'h0B;
            7'b1000110: decode = 5'h0C;
            7'b0100001: decode = 5'h0D;
            7'b0000110: decode = 5'h0E;
            7'b0001110: decode = 5'h0F;
            7'b1111111: decode = 5'h10;
            default:    decode = 5'h1F;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
        end
    end

    always_comb begin
        zeros = '0;
        sel   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s2[i]) begin
                zeros = zeros + 4'd1;
                sel   = 3'(i);
            end
        end
        one_hot = (zeros == 4'd1);
        code    = decode(seg_s2);
        sample  = (an_s1 == an_s2) && one_hot && (settle == 8'(SETTLE_CYC - 1));
    end

    // The counter is cleared on the same edge the synchronized anodes change, so it
    // reaches SETTLE_CYC exactly SETTLE_CYC cycles after a new pattern appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= '0;
        end else if ((an_s1 != an_s2) || !one_hot) begin
            settle <= '0;
        end else if (settle != 8'(SETTLE_CYC)) begin
            settle <= settle + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand[i]      <= 5'h1F;
                match_cnt[i] <= '0;
            end
            pend      <= 1'b0;
            pend_idx  <= '0;
            pend_code <= '0;
        end else begin
            pend <= 1'b0;
            if (sample) begin
                pend_idx  <= sel;
                pend_code <= code;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel == 3'(i)) begin
                        if (code == cand[i]) begin
                            if (match_cnt[i] < 4'(STABLE_CNT))
                                match_cnt[i] <= match_cnt[i] + 4'd1;
                            // Only the sample that lifts the count onto STABLE_CNT may commit.
                            pend <= (match_cnt[i] == 4'(STABLE_CNT - 1)) &&
                                    (!digit_valid[i] || (digits[5*i +: 5] != code));
                        end else begin
                            cand[i]      <= code;
                            match_cnt[i] <= 4'd1;
                            pend <= (STABLE_CNT == 1) &&
                                    (!digit_valid[i] || (digits[5*i +: 5] != code));
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
        end else begin
            upd <= pend;
            if (pend) begin
                upd_idx <= pend_idx;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (pend_idx == 3'(i)) begin
                        digits[5*i +: 5] <= pend_code;
                        digit_valid[i]   <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SSD_READER_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (pend && (pend_code == 5'h1F) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ssd_reader.sv
// Scoreboard bench for ssd_reader: a behavioural model predicts commits per activation and
// the expected commits are compared against upd pulses as they appear.
module tb_ssd_reader;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int ST = 3;
    localparam int FULL = SC + 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      seg_in;
    logic [ND-1:0]   an_in;
    logic [5*ND-1:0] digits;
    logic [ND-1:0]   digit_valid;
    logic            upd;
    logic [2:0]      upd_idx;
`ifdef SSD_READER_ERRCNT_EN
    logic [7:0]      err_cnt;
    int              m_err = 0;
`endif

    ssd_reader #(.NUM_DIGITS(ND), .SETTLE_CYC(SC), .STABLE_CNT(ST)) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .an_in(an_in),
        .digits(digits),
        .digit_valid(digit_valid),
        .upd(upd),
        .upd_idx(upd_idx)
`ifdef SSD_READER_ERRCNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] idx;
        logic [4:0] code;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic [6:0] pat_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [4:0]    m_cand [ND];
    int            m_cnt  [ND];
    logic [4:0]    m_dig  [ND];
    logic [ND-1:0] m_val;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (s == pat_tab[k]) return 5'(k);
        if (s == 7'h7F) return 5'h10;
        return 5'h1F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_cand[i] = 5'h1F;
            m_cnt[i]  = 0;
            m_dig[i]  = 5'h00;
        end
        m_val = '0;
        sb.delete();
`ifdef SSD_READER_ERRCNT_EN
        m_err = 0;
`endif
    endtask

    // One sample for digit d: returns whether a commit is predicted and queues it.
    task automatic model_sample(input int d, input logic [4:0] c, output bit commit);
        bit reached;
        exp_t e;
        reached = 0;
        if (c == m_cand[d]) begin
            if (m_cnt[d] < ST) begin
                m_cnt[d]++;
                reached = (m_cnt[d] == ST);
            end
        end else begin
            m_cand[d] = c;
            m_cnt[d]  = 1;
            reached   = (ST == 1);
        end
        commit = reached && (!m_val[d] || (m_dig[d] != c));
        if (commit) begin
            m_dig[d] = c;
            m_val[d] = 1'b1;
            e.idx  = 3'(d);
            e.code = c;
            sb.push_back(e);
`ifdef SSD_READER_ERRCNT_EN
            if (c == 5'h1F && m_err < 255) m_err++;
`endif
        end
    endtask

    // Blank gap, then one anode activation held for 'hold' cycles.
    task automatic applyStimulus(input int d, input logic [6:0] seg, input int hold);
        bit   commit;
        int   ups;
        exp_t e;
        @(negedge clk);
        an_in = '1;
        repeat (2) @(negedge clk);
        an_in  = ~(ND'(1) << d);
        seg_in = seg;
        commit = 0;
        if (hold >= FULL) model_sample(d, model_decode(seg), commit);
        ups = 0;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            if (upd) begin
                ups++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_upd", 32'(upd), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("upd_idx", 32'(upd_idx), 32'(e.idx));
                    checkOutput("digit_code", 32'(digits[5*e.idx +: 5]), 32'(e.code));
                    checkOutput("upd_latency", k, SC + 3);
                end
            end
        end
        checkOutput("upd_pulses", ups, 32'(commit));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst    = 1'b1;
        an_in  = '1;
        seg_in = '1;
        model_reset();
        repeat (3) @(negedge clk);
        checkOutput("rst_digits", 32'(digits), 32'd0);
        checkOutput("rst_valid", 32'(digit_valid), 32'd0);
        checkOutput("rst_upd", 32'(upd), 32'd0);
        checkOutput("rst_upd_idx", 32'(upd_idx), 32'd0);
`ifdef SSD_READER_ERRCNT_EN
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;

        // digit 0 shows "2" for three activations
        for (int j = 0; j < 3; j++) applyStimulus(0, 7'b0100100, FULL);
        checkOutput("d0_code", 32'(digits[4:0]), 32'h02);
        checkOutput("valid_d0", 32'(digit_valid), 32'b0001);

        // digit 1 flickers between "1" and "3": never stable
        for (int j = 0; j < 6; j++) applyStimulus(1, (j % 2 == 0) ? 7'b1111001 : 7'b0110000, FULL);
        checkOutput("d1_not_valid", 32'(digit_valid[1]), 32'd0);

        // two samples of "5", a short glitch showing "7", then a third "5"
        applyStimulus(1, 7'b0010010, FULL);
        applyStimulus(1, 7'b0010010, FULL);
        applyStimulus(1, 7'b1111000, 3);
        applyStimulus(1, 7'b1111000, 3);
        applyStimulus(1, 7'b0010010, FULL);
        checkOutput("d1_after_glitch", 32'(digits[9:5]), 32'h05);

        // digit 2: "A" committed once, repeated scans silent, then blank
        for (int j = 0; j < 6; j++) applyStimulus(2, 7'b0001000, FULL);
        checkOutput("d2_code_A", 32'(digits[14:10]), 32'h0A);
        for (int j = 0; j < 3; j++) applyStimulus(2, 7'b1111111, FULL);
        checkOutput("d2_blank", 32'(digits[14:10]), 32'h10);

        // digit 3: an undecodable pattern commits the invalid code
        for (int j = 0; j < 3; j++) applyStimulus(3, 7'b0101010, FULL);
        checkOutput("d3_invalid", 32'(digits[19:15]), 32'h1F);
`ifdef SSD_READER_ERRCNT_EN
        checkOutput("err_cnt_one", 32'(err_cnt), 32'd1);
`endif

        // reset after two matching samples of "0" on digit 3
        applyStimulus(3, 7'b1000000, FULL);
        applyStimulus(3, 7'b1000000, FULL);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_digits", 32'(digits), 32'd0);
        checkOutput("midrst_valid", 32'(digit_valid), 32'd0);
        checkOutput("midrst_upd", 32'(upd), 32'd0);
        checkOutput("midrst_upd_idx", 32'(upd_idx), 32'd0);
`ifdef SSD_READER_ERRCNT_EN
        checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(3, 7'b1000000, FULL);
        applyStimulus(3, 7'b1000000, FULL);
        checkOutput("reacq_not_yet", 32'(digit_valid), 32'd0);
        applyStimulus(3, 7'b1000000, FULL);
        checkOutput("reacq_valid", 32'(digit_valid), 32'b1000);
        checkOutput("reacq_code", 32'(digits[19:15]), 32'h00);

`ifdef SSD_READER_ERRCNT_EN
        // 300 invalid commits on digit 0, each separated by a valid commit
        for (int n = 0; n < 300; n++) begin
            for (int j = 0; j < 3; j++) applyStimulus(0, 7'b0101010, FULL);
            for (int j = 0; j < 3; j++) applyStimulus(0, 7'b1111001, FULL);
            if (n == 9) checkOutput("err_cnt_10", 32'(err_cnt), 32'(m_err));
        end
        checkOutput("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
